// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// valid/ready producers; bursts of up to MAX_BURST beats, writes gated on fifo_full.
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 4,
   localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wren,
   output logic [DATA_WIDTH-1:0]         fifo_wrdata,
   output logic [ID_W-1:0]               grant_id,
   output logic                          busy
);

   localparam int unsigned BCW = $clog2(MAX_BURST + 1);
   localparam int unsigned SW  = ID_W + 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_owner;
   logic [ID_W-1:0]     w_owner_nxt;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     w_rr_ptr_nxt;
   logic [BCW-1:0]      r_burst_cnt;
   logic [BCW-1:0]      w_burst_nxt;
   logic [ID_W-1:0]     w_sel;
   logic                w_sel_found;
   logic [SW-1:0]       w_sum;
   logic [ID_W-1:0]     w_owner_inc;
   logic                w_owner_valid;
   logic [DATA_WIDTH-1:0] w_owner_data;
   logic                w_xfer;

   // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      w_sel       = '0;
      w_sel_found = 1'b0;
      w_sum       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + SW'(k);
         if (w_sum >= SW'(NUM_REQ)) begin
            w_sum = w_sum - SW'(NUM_REQ);
         end
         if (!w_sel_found && req_valid[w_sum[ID_W-1:0]]) begin
            w_sel       = w_sum[ID_W-1:0];
            w_sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_owner_valid = 1'b0;
      w_owner_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_owner == ID_W'(i)) begin
            w_owner_valid = req_valid[i];
            w_owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_owner_inc = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);

   // Next state and combinational write-port outputs; rst suppresses any write
   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_rr_ptr_nxt = r_rr_ptr;
      w_burst_nxt  = r_burst_cnt;
      w_xfer       = 1'b0;
      req_ready    = '0;
      fifo_wren    = 1'b0;
      fifo_wrdata  = '0;
      case (r_state)
         S_IDLE: begin
            if (w_sel_found) begin
               w_owner_nxt = w_sel;
               w_burst_nxt = '0;
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!fifo_full && !rst) begin
               req_ready = NUM_REQ'(1) << r_owner;
            end
            w_xfer = w_owner_valid && !fifo_full && !rst;
            if (w_xfer) begin
               fifo_wren   = 1'b1;
               fifo_wrdata = w_owner_data;
               w_burst_nxt = r_burst_cnt + BCW'(1);
            end
            if (!w_owner_valid || (w_xfer && (w_burst_nxt == BCW'(MAX_BURST)))) begin
               w_state_nxt  = S_IDLE;
               w_rr_ptr_nxt = w_owner_inc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_burst_cnt <= w_burst_nxt;
      end
   end

   assign grant_id = r_owner;
   assign busy     = (r_state == S_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic, every
// cycle compared against a cycle-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned DW      = 32;
   localparam int unsigned MAXB    = 4;
   localparam int unsigned ID_W    = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ*DW-1:0]  req_data;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   fifo_full;
   logic                   fifo_wren;
   logic [DW-1:0]          fifo_wrdata;
   logic [ID_W-1:0]        grant_id;
   logic                   busy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_wren   (fifo_wren),
      .fifo_wrdata (fifo_wrdata),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Producer-side pending beats, observed FIFO writes and grant history
   logic [DW-1:0] pq [NUM_REQ][$];
   logic [DW-1:0] sent [$];
   logic [DW-1:0] fifo_q [$];
   bit            wr_bits [$];
   int            gseq [$];
   int            wcnt [NUM_REQ];

   // Reference model state
   bit m_busy = 1'b0;
   int m_owner = 0;
   int m_ptr = 0;
   int m_cnt = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      fifo_q.delete();
      wr_bits.delete();
      gseq.delete();
      sent.delete();
      for (int i = 0; i < NUM_REQ; i++) wcnt[i] = 0;
   endtask

   task automatic clear_queues();
      for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
   endtask

   // One clock cycle: drive producers, compare outputs to the model, advance both
   task automatic step();
      logic [NUM_REQ-1:0] e_ready;
      logic [DW-1:0]      e_data;
      bit                 xfer;
      int                 cand;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]         = (pq[i].size() != 0);
         req_data[i*DW +: DW] = req_valid[i] ? pq[i][0] : '0;
      end
      @(negedge clk);
      xfer    = m_busy && req_valid[m_owner] && !fifo_full && !rst;
      e_ready = (m_busy && !fifo_full && !rst) ? (NUM_REQ'(1) << m_owner) : '0;
      e_data  = xfer ? req_data[m_owner*DW +: DW] : '0;
      check_eq("req_ready", 64'(req_ready), 64'(e_ready));
      check_eq("fifo_wren", 64'(fifo_wren), 64'(xfer));
      check_eq("fifo_wrdata", 64'(fifo_wrdata), 64'(e_data));
      check_eq("grant_id", 64'(grant_id), 64'(m_owner));
      check_eq("busy", 64'(busy), 64'(m_busy));
      wr_bits.push_back(fifo_wren);
      if (fifo_wren === 1'b1) begin
         wcnt[grant_id]++;
         fifo_q.push_back(fifo_wrdata);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] && (req_ready[i] === 1'b1)) void'(pq[i].pop_front());
      end
      if (rst) begin
         m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_busy) begin
         for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = (m_ptr + k) % NUM_REQ;
            if (!m_busy && req_valid[cand]) begin
               m_busy = 1'b1; m_owner = cand; m_cnt = 0;
               gseq.push_back(cand);
            end
         end
      end else begin
         if (xfer) m_cnt++;
         if (!req_valid[m_owner] || (m_cnt == int'(MAXB))) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NUM_REQ;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic push(input int p, input logic [DW-1:0] d);
      pq[p].push_back(d);
      sent.push_back(d);
   endtask

   initial begin
      logic [9:0] pat10;
      logic [8:0] pat9;
      int         pending;
      rst       = 1'b1;
      fifo_full = 1'b0;
      req_valid = '0;
      req_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Single producer 2 streams 8 beats: idle, 4 writes, idle, 4 writes
      clear_logs();
      for (int j = 0; j < 8; j++) push(2, DW'(32'hA000_0000 + j));
      repeat (12) step();
      for (int j = 0; j < 10; j++) pat10[9-j] = wr_bits[j];
      check_eq("t1_pattern", 64'(pat10), 64'(10'b0111101111));
      check_eq("t1_count", 64'(fifo_q.size()), 64'd8);
      for (int j = 0; j < 8 && j < fifo_q.size(); j++)
         check_eq("t1_order", 64'(fifo_q[j]), 64'(sent[j]));
      check_eq("t1_cnt2", 64'(wcnt[2]), 64'd8);

      // Fairness: all four hold valid -> grants 0,1,2,3,0 with 4 writes each
      do_reset();
      clear_logs();
      for (int p = 0; p < 4; p++)
         for (int j = 0; j < 8; j++) push(p, DW'($urandom));
      repeat (21) step();
      for (int p = 0; p < 4; p++) check_eq("t2_wcnt", 64'(wcnt[p]), 64'd4);
      check_eq("t2_ngrants", 64'(gseq.size()), 64'd5);
      for (int j = 0; j < 5 && j < gseq.size(); j++)
         check_eq("t2_order", 64'(gseq[j]), 64'(j % 4));
      clear_queues();

      // Backpressure: full for 3 cycles after 2 beats, burst resumes
      do_reset();
      clear_logs();
      for (int j = 0; j < 4; j++) push(1, DW'($urandom));
      repeat (3) step();
      fifo_full = 1'b1;
      repeat (3) step();
      fifo_full = 1'b0;
      repeat (3) step();
      for (int j = 0; j < 9; j++) pat9[8-j] = wr_bits[j];
      check_eq("t3_pattern", 64'(pat9), 64'(9'b011000110));
      check_eq("t3_count", 64'(fifo_q.size()), 64'd4);
      for (int j = 0; j < 4 && j < fifo_q.size(); j++)
         check_eq("t3_order", 64'(fifo_q[j]), 64'(sent[j]));

      // Early release with wrap: ptr to 3 via producer 2, then 3 and 0 compete
      do_reset();
      clear_logs();
      push(2, DW'($urandom));
      repeat (3) step();
      push(3, DW'($urandom));
      push(0, DW'($urandom));
      push(0, DW'($urandom));
      repeat (6) step();
      check_eq("t4_ngrants", 64'(gseq.size()), 64'd3);
      if (gseq.size() >= 3) begin
         check_eq("t4_g1", 64'(gseq[1]), 64'd3);
         check_eq("t4_g2", 64'(gseq[2]), 64'd0);
      end
      clear_queues();

      // Reset mid-burst of producer 1, then 0 and 1 compete
      do_reset();
      clear_logs();
      for (int j = 0; j < 8; j++) push(1, DW'($urandom));
      repeat (3) step();
      do_reset();
      push(0, DW'($urandom));
      step();
      check_eq("t5_busy_after_rst", 64'(busy), 64'd1);
      check_eq("t5_grant", 64'(gseq[gseq.size()-1]), 64'd0);
      check_eq("t5_writes", 64'(fifo_q.size()), 64'd2);
      clear_queues();

      // Randomized traffic, backpressure and occasional reset
      do_reset();
      clear_logs();
      for (int c = 0; c < 1500; c++) begin
         for (int p = 0; p < 4; p++)
            if (pq[p].size() < 3 && $urandom_range(3, 0) == 0) push(p, DW'($urandom));
         fifo_full = ($urandom_range(4, 0) == 0);
         rst       = ($urandom_range(199, 0) == 0);
         step();
      end
      rst       = 1'b0;
      fifo_full = 1'b0;
      pending   = 1;
      for (int c = 0; c < 300 && pending != 0; c++) begin
         step();
         pending = 0;
         for (int p = 0; p < 4; p++) pending += pq[p].size();
      end
      check_eq("drain", 64'(pending), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
